// File: rtl/cue_aim_pkg.sv
// Shared types and Q1.6 direction tables for the cue sight controller.
package cue_aim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_AIM    = 2'd1,
      ST_CHARGE = 2'd2,
      ST_WAIT   = 2'd3
   } aim_state_t;

   // Fixed-point shift for the Q1.6 direction values
   localparam int Q_SHIFT = 6;

   // round(64*cos(2*pi*k/64)), clipped to the signed 8-bit range 63..-64
   localparam logic signed [7:0] COS_LUT [64] = '{
       8'sd63,  8'sd63,  8'sd63,  8'sd61,  8'sd59,  8'sd56,  8'sd53,  8'sd49,
       8'sd45,  8'sd41,  8'sd36,  8'sd30,  8'sd24,  8'sd19,  8'sd12,   8'sd6,
        8'sd0,  -8'sd6, -8'sd12, -8'sd19, -8'sd24, -8'sd30, -8'sd36, -8'sd41,
      -8'sd45, -8'sd49, -8'sd53, -8'sd56, -8'sd59, -8'sd61, -8'sd63, -8'sd64,
      -8'sd64, -8'sd64, -8'sd63, -8'sd61, -8'sd59, -8'sd56, -8'sd53, -8'sd49,
      -8'sd45, -8'sd41, -8'sd36, -8'sd30, -8'sd24, -8'sd19, -8'sd12,  -8'sd6,
        8'sd0,   8'sd6,  8'sd12,  8'sd19,  8'sd24,  8'sd30,  8'sd36,  8'sd41,
       8'sd45,  8'sd49,  8'sd53,  8'sd56,  8'sd59,  8'sd61,  8'sd63,  8'sd63
   };

   // round(64*sin(2*pi*k/64)), same clipping; +Y is screen-down
   localparam logic signed [7:0] SIN_LUT [64] = '{
        8'sd0,   8'sd6,  8'sd12,  8'sd19,  8'sd24,  8'sd30,  8'sd36,  8'sd41,
       8'sd45,  8'sd49,  8'sd53,  8'sd56,  8'sd59,  8'sd61,  8'sd63,  8'sd63,
       8'sd63,  8'sd63,  8'sd63,  8'sd61,  8'sd59,  8'sd56,  8'sd53,  8'sd49,
       8'sd45,  8'sd41,  8'sd36,  8'sd30,  8'sd24,  8'sd19,  8'sd12,   8'sd6,
        8'sd0,  -8'sd6, -8'sd12, -8'sd19, -8'sd24, -8'sd30, -8'sd36, -8'sd41,
      -8'sd45, -8'sd49, -8'sd53, -8'sd56, -8'sd59, -8'sd61, -8'sd63, -8'sd64,
      -8'sd64, -8'sd64, -8'sd63, -8'sd61, -8'sd59, -8'sd56, -8'sd53, -8'sd49,
      -8'sd45, -8'sd41, -8'sd36, -8'sd30, -8'sd24, -8'sd19, -8'sd12,  -8'sd6
   };

endpackage

// File: rtl/cue_dir_lut.sv
// Angle to unit-direction lookup; coarser angle resolutions stride the 64-entry tables.
module cue_dir_lut
   import cue_aim_pkg::*;
#(
   parameter int ANGLE_BITS = 5
) (
   input  logic [ANGLE_BITS-1:0] angle,
   output logic signed [7:0]     cos_val,
   output logic signed [7:0]     sin_val
);

   logic [5:0] idx;

   assign idx     = 6'(angle) << (6 - ANGLE_BITS);
   assign cos_val = COS_LUT[idx];
   assign sin_val = SIN_LUT[idx];

endmodule

// File: rtl/cue_aim_ctrl.sv
// Cue sight placement, angle control and shot launch, advanced once per video frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | sight hidden, waiting for all balls to stop
// ST_AIM    | sight shown, left/right rotate it, Enter starts charging
// ST_CHARGE | sight shown, power ramps while Enter is held
// ST_WAIT   | shot launched, waiting for motion or the frame timeout
module cue_aim_ctrl
   import cue_aim_pkg::*;
#(
   parameter int W             = 11,
   parameter int ANGLE_BITS    = 5,
   parameter int RADIUS        = 40,
   parameter int CENTER_OFS    = 12,
   parameter int RESET_X       = 440,
   parameter int RESET_Y       = 224,
   parameter int POWER_BITS    = 6,
   parameter int POWER_STEP    = 2,
   parameter int POWER_MAX     = 63,
   parameter int REPEAT_FRAMES = 4,
   parameter int WAIT_TIMEOUT  = 30
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  startOfFrame,
   input  logic                  stop0,
   input  logic                  keyLeft,
   input  logic                  keyRight,
   input  logic                  keyEnter,
   input  logic signed [W-1:0]   topLeftX_WhiteBall,
   input  logic signed [W-1:0]   topLeftY_WhiteBall,
   output logic signed [W-1:0]   topLeftX,
   output logic signed [W-1:0]   topLeftY,
   output logic                  sightVisible,
   output logic                  shotValid,
   output logic signed [7:0]     shotDirX,
   output logic signed [7:0]     shotDirY,
   output logic [POWER_BITS-1:0] shotPower
);

   localparam int RW  = $clog2(REPEAT_FRAMES + 1);
   localparam int WTW = $clog2(WAIT_TIMEOUT + 1);
   localparam int PW1 = POWER_BITS + 1;

   localparam logic [RW-1:0]         REP_LOAD  = RW'(REPEAT_FRAMES - 1);
   localparam logic [WTW-1:0]        WAIT_LOAD = WTW'(WAIT_TIMEOUT - 1);
   localparam logic signed [15:0]    RAD16     = 16'(RADIUS);

   aim_state_t            state, state_n;
   logic [ANGLE_BITS-1:0] angle, angle_n;
   logic [RW-1:0]         rep_cnt, rep_n;
   logic [WTW-1:0]        wait_cnt, wait_n;
   logic [POWER_BITS-1:0] power, power_n;
   logic [PW1-1:0]        pwr_sum;

   logic signed [W-1:0]   x_n, y_n, pos_x, pos_y;
   logic                  vis_n, valid_n;
   logic signed [7:0]     dirx_n, diry_n;
   logic [POWER_BITS-1:0] spow_n;

   logic signed [7:0]     lut_cos, lut_sin;
   logic signed [15:0]    prod_x, prod_y;

   // Direction follows the next angle so a step shows up in the same frame's sight
   cue_dir_lut #(
      .ANGLE_BITS (ANGLE_BITS)
   ) u_dir_lut (
      .angle   (angle_n),
      .cos_val (lut_cos),
      .sin_val (lut_sin)
   );

   assign prod_x  = 16'(lut_cos) * RAD16;
   assign prod_y  = 16'(lut_sin) * RAD16;
   assign pos_x   = topLeftX_WhiteBall + W'(CENTER_OFS) + W'(prod_x >>> Q_SHIFT);
   assign pos_y   = topLeftY_WhiteBall + W'(CENTER_OFS) + W'(prod_y >>> Q_SHIFT);
   assign pwr_sum = {1'b0, power} + PW1'(POWER_STEP);

   // Angle stepping with auto-repeat; only a single held key in AIM steps the angle
   always_comb begin
      angle_n = angle;
      rep_n   = rep_cnt;
      if (startOfFrame) begin
         if (state == ST_AIM && stop0 && !keyEnter && (keyLeft ^ keyRight)) begin
            if (rep_cnt == '0) begin
               angle_n = keyRight ? angle + ANGLE_BITS'(1) : angle - ANGLE_BITS'(1);
               rep_n   = REP_LOAD;
            end else begin
               rep_n = rep_cnt - RW'(1);
            end
         end else begin
            rep_n = '0;
         end
      end
   end

   // Next-state, power, wait timer and registered-output values
   always_comb begin
      state_n = state;
      power_n = power;
      wait_n  = wait_cnt;
      x_n     = topLeftX;
      y_n     = topLeftY;
      vis_n   = sightVisible;
      valid_n = 1'b0;
      dirx_n  = shotDirX;
      diry_n  = shotDirY;
      spow_n  = shotPower;
      if (startOfFrame) begin
         case (state)
            ST_IDLE: begin
               if (stop0) state_n = ST_AIM;
            end
            ST_AIM: begin
               if (!stop0) begin
                  state_n = ST_IDLE;
                  power_n = '0;
               end else if (keyEnter) begin
                  state_n = ST_CHARGE;
                  power_n = POWER_BITS'(POWER_STEP);
               end
            end
            ST_CHARGE: begin
               if (!stop0) begin
                  state_n = ST_IDLE;
                  power_n = '0;
               end else if (!keyEnter) begin
                  state_n = ST_WAIT;
                  valid_n = 1'b1;
                  dirx_n  = lut_cos;
                  diry_n  = lut_sin;
                  spow_n  = power;
                  power_n = '0;
                  wait_n  = WAIT_LOAD;
               end else if (pwr_sum > PW1'(POWER_MAX)) begin
                  power_n = POWER_BITS'(POWER_MAX);
               end else begin
                  power_n = pwr_sum[POWER_BITS-1:0];
               end
            end
            ST_WAIT: begin
               // Timeout stops a zero-motion shot from parking the controller here
               if (!stop0 || wait_cnt == '0) begin
                  state_n = ST_IDLE;
               end else begin
                  wait_n = wait_cnt - WTW'(1);
               end
            end
            default: state_n = ST_IDLE;
         endcase
         vis_n = (state_n == ST_AIM) || (state_n == ST_CHARGE);
         if (vis_n) begin
            x_n = pos_x;
            y_n = pos_y;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= ST_IDLE;
         angle        <= '0;
         rep_cnt      <= '0;
         wait_cnt     <= '0;
         power        <= '0;
         topLeftX     <= W'(RESET_X);
         topLeftY     <= W'(RESET_Y);
         sightVisible <= 1'b0;
         shotValid    <= 1'b0;
         shotDirX     <= '0;
         shotDirY     <= '0;
         shotPower    <= '0;
      end else begin
         state        <= state_n;
         angle        <= angle_n;
         rep_cnt      <= rep_n;
         wait_cnt     <= wait_n;
         power        <= power_n;
         topLeftX     <= x_n;
         topLeftY     <= y_n;
         sightVisible <= vis_n;
         shotValid    <= valid_n;
         shotDirX     <= dirx_n;
         shotDirY     <= diry_n;
         shotPower    <= spow_n;
      end
   end

endmodule

// File: tb/tb_cue_aim_ctrl.sv
// Self-checking bench for cue_aim_ctrl; shots are scoreboarded through a queue.
module tb_cue_aim_ctrl;

   localparam int W = 11;

   logic                clk = 1'b0;
   logic                resetN, startOfFrame, stop0, keyLeft, keyRight, keyEnter;
   logic signed [W-1:0] ballX, ballY, topLeftX, topLeftY;
   logic                sightVisible, shotValid;
   logic signed [7:0]   shotDirX, shotDirY;
   logic [5:0]          shotPower;

   int n_tests = 0;
   int n_fail  = 0;
   int shot_seen = 0;

   typedef struct {int dx; int dy; int pw;} shot_t;
   shot_t shot_q[$];

   cue_aim_ctrl dut (
      .clk                (clk),
      .resetN             (resetN),
      .startOfFrame       (startOfFrame),
      .stop0              (stop0),
      .keyLeft            (keyLeft),
      .keyRight           (keyRight),
      .keyEnter           (keyEnter),
      .topLeftX_WhiteBall (ballX),
      .topLeftY_WhiteBall (ballY),
      .topLeftX           (topLeftX),
      .topLeftY           (topLeftY),
      .sightVisible       (sightVisible),
      .shotValid          (shotValid),
      .shotDirX           (shotDirX),
      .shotDirY           (shotDirY),
      .shotPower          (shotPower)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference Q1.6 trig for a 5-bit angle, computed from real math
   function automatic int ref_trig(input int ang, input bit is_sin);
      real a, r;
      int  v;
      a = 2.0 * 3.14159265358979 * real'((ang * 2) % 64) / 64.0;
      r = 64.0 * (is_sin ? $sin(a) : $cos(a));
      if (r >= 0.0) v = $rtoi(r + 0.5);
      else          v = -$rtoi(-r + 0.5);
      if (v > 63)  v = 63;
      if (v < -64) v = -64;
      return v;
   endfunction

   function automatic int ref_pos(input int base, input int trig);
      int s;
      s = base + 12 + ((trig * 40) >>> 6);
      s = s & 2047;
      if (s >= 1024) s = s - 2048;
      return s;
   endfunction

   task automatic tick(input bit s, input bit l, input bit r, input bit e);
      @(negedge clk);
      startOfFrame = 1'b1;
      stop0        = s;
      keyLeft      = l;
      keyRight     = r;
      keyEnter     = e;
      @(negedge clk);
      startOfFrame = 1'b0;
   endtask

   // Shot scoreboard: every pulse must match the oldest expected shot and last one clk
   bit    prev_valid = 1'b0;
   shot_t got_exp;
   always @(negedge clk) begin
      if (shotValid) begin
         shot_seen++;
         n_tests++;
         if (prev_valid) begin
            n_fail++;
            $display("FAIL shot_width: shotValid high on consecutive cycles, required one cycle");
         end else if (shot_q.size() == 0) begin
            n_fail++;
            $display("FAIL shot_unexpected: dir=(%0d,%0d) power=%0d, required no shot",
                     shotDirX, shotDirY, shotPower);
         end else begin
            got_exp = shot_q.pop_front();
            if (int'(shotDirX) !== got_exp.dx || int'(shotDirY) !== got_exp.dy ||
                int'(shotPower) !== got_exp.pw) begin
               n_fail++;
               $display("FAIL shot_payload: got dir=(%0d,%0d) power=%0d, required dir=(%0d,%0d) power=%0d",
                        shotDirX, shotDirY, shotPower, got_exp.dx, got_exp.dy, got_exp.pw);
            end
         end
      end
      prev_valid = shotValid;
   end

   task automatic test_reset();
      resetN = 1'b0; startOfFrame = 1'b0; stop0 = 1'b0;
      keyLeft = 1'b0; keyRight = 1'b0; keyEnter = 1'b0;
      ballX = 11'sd100; ballY = 11'sd200;
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      n_tests++;
      if (topLeftX !== 11'sd440 || topLeftY !== 11'sd224) begin
         n_fail++;
         $display("FAIL reset_pos: got (%0d,%0d) required (440,224)", topLeftX, topLeftY);
      end
      n_tests++;
      if (sightVisible !== 1'b0 || shotValid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: vis=%b valid=%b required 0 0", sightVisible, shotValid);
      end
      n_tests++;
      if (shotDirX !== 8'sd0 || shotDirY !== 8'sd0 || shotPower !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_shot: dir=(%0d,%0d) power=%0d required zeros", shotDirX, shotDirY, shotPower);
      end
      // No tick yet: the sight must not move without startOfFrame
      stop0 = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (sightVisible !== 1'b0 || topLeftX !== 11'sd440) begin
         n_fail++;
         $display("FAIL no_tick_hold: vis=%b x=%0d required 0 440", sightVisible, topLeftX);
      end
   endtask

   task automatic test_arm();
      tick(1, 0, 0, 0);
      n_tests++;
      if (topLeftX !== 11'sd151 || topLeftY !== 11'sd212 || sightVisible !== 1'b1) begin
         n_fail++;
         $display("FAIL arm: got (%0d,%0d) vis=%b required (151,212) vis=1", topLeftX, topLeftY, sightVisible);
      end
   endtask

   task automatic test_angle_repeat();
      int ea;
      for (int t = 1; t <= 9; t++) begin
         tick(1, 0, 1, 0);
         ea = (t - 1) / 4 + 1;
         n_tests++;
         if (int'(topLeftX) !== ref_pos(100, ref_trig(ea, 0)) ||
             int'(topLeftY) !== ref_pos(200, ref_trig(ea, 1))) begin
            n_fail++;
            $display("FAIL repeat_t%0d: got (%0d,%0d) required (%0d,%0d)", t, topLeftX, topLeftY,
                     ref_pos(100, ref_trig(ea, 0)), ref_pos(200, ref_trig(ea, 1)));
         end
      end
      n_tests++;
      if (topLeftX !== 11'sd145 || topLeftY !== 11'sd234) begin
         n_fail++;
         $display("FAIL angle3_pos: got (%0d,%0d) required (145,234)", topLeftX, topLeftY);
      end
      tick(1, 0, 0, 0);
      for (int t = 0; t < 3; t++) begin
         tick(1, 1, 1, 0);
         n_tests++;
         if (topLeftX !== 11'sd145 || topLeftY !== 11'sd234) begin
            n_fail++;
            $display("FAIL both_keys_%0d: got (%0d,%0d) required (145,234)", t, topLeftX, topLeftY);
         end
      end
      tick(1, 0, 0, 0);
   endtask

   task automatic test_left_wrap();
      for (int t = 0; t < 3; t++) begin
         tick(1, 1, 0, 0);
         tick(1, 0, 0, 0);
      end
      n_tests++;
      if (topLeftX !== 11'sd151 || topLeftY !== 11'sd212) begin
         n_fail++;
         $display("FAIL left_to_0: got (%0d,%0d) required (151,212)", topLeftX, topLeftY);
      end
      tick(1, 1, 0, 0);
      n_tests++;
      if (topLeftX !== 11'sd151 || topLeftY !== 11'sd204) begin
         n_fail++;
         $display("FAIL left_wrap_31: got (%0d,%0d) required (151,204)", topLeftX, topLeftY);
      end
      tick(1, 0, 0, 0);
   endtask

   task automatic test_position_wrap();
      ballX = 11'sd1020; ballY = -11'sd1020;
      tick(1, 0, 0, 0);
      n_tests++;
      if (int'(topLeftX) !== -977 || int'(topLeftY) !== -1016) begin
         n_fail++;
         $display("FAIL pos_wrap: got (%0d,%0d) required (-977,-1016)", topLeftX, topLeftY);
      end
      ballX = 11'sd100; ballY = 11'sd200;
      tick(1, 0, 0, 0);
   endtask

   task automatic test_charge_saturate();
      for (int t = 0; t < 40; t++) tick(1, 0, 0, 1);
      n_tests++;
      if (sightVisible !== 1'b1 || topLeftX !== 11'sd151 || topLeftY !== 11'sd204) begin
         n_fail++;
         $display("FAIL charge_sight: vis=%b (%0d,%0d) required vis=1 (151,204)", sightVisible, topLeftX, topLeftY);
      end
      shot_q.push_back('{ref_trig(31, 0), ref_trig(31, 1), 63});
      tick(1, 0, 0, 0);
      n_tests++;
      if (sightVisible !== 1'b0) begin
         n_fail++;
         $display("FAIL fire_hide: vis=%b required 0", sightVisible);
      end
      @(negedge clk);
      n_tests++;
      if (shot_q.size() != 0 || shotValid !== 1'b0 || shotPower !== 6'd63) begin
         n_fail++;
         $display("FAIL fire_after: pending=%0d valid=%b power=%0d required 0 0 63",
                  shot_q.size(), shotValid, shotPower);
      end
   endtask

   task automatic test_wait_timeout();
      for (int t = 1; t <= 30; t++) begin
         tick(1, 0, 0, 0);
         n_tests++;
         if (sightVisible !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_t%0d: vis=%b required 0", t, sightVisible);
         end
      end
      tick(1, 0, 0, 0);
      n_tests++;
      if (sightVisible !== 1'b1 || topLeftX !== 11'sd151 || topLeftY !== 11'sd204) begin
         n_fail++;
         $display("FAIL wait_rearm: vis=%b (%0d,%0d) required vis=1 (151,204)", sightVisible, topLeftX, topLeftY);
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 5; t++) tick(1, 0, 0, 1);
      shot_q.push_back('{ref_trig(31, 0), ref_trig(31, 1), 10});
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      n_tests++;
      if (sightVisible !== 1'b0) begin
         n_fail++;
         $display("FAIL motion_idle: vis=%b required 0", sightVisible);
      end
      tick(1, 0, 0, 0);
      n_tests++;
      if (sightVisible !== 1'b1 || shot_q.size() != 0) begin
         n_fail++;
         $display("FAIL motion_rearm: vis=%b pending=%0d required vis=1 pending=0", sightVisible, shot_q.size());
      end
   endtask

   task automatic test_abort();
      int seen0;
      seen0 = shot_seen;
      for (int t = 0; t < 5; t++) tick(1, 0, 0, 1);
      tick(0, 0, 0, 1);
      n_tests++;
      if (sightVisible !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_hide: vis=%b required 0", sightVisible);
      end
      tick(1, 0, 0, 0);
      @(negedge clk);
      n_tests++;
      if (shot_seen != seen0 || sightVisible !== 1'b1 || topLeftY !== 11'sd204) begin
         n_fail++;
         $display("FAIL abort_noshot: shots=%0d vis=%b y=%0d required shots=%0d vis=1 y=204",
                  shot_seen - seen0, sightVisible, topLeftY, 0);
      end
      shot_q.push_back('{ref_trig(31, 0), ref_trig(31, 1), 2});
      tick(1, 0, 0, 1);
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      @(negedge clk);
      n_tests++;
      if (shot_seen != seen0 + 1) begin
         n_fail++;
         $display("FAIL min_power_shot: shots=%0d required 1", shot_seen - seen0);
      end
   endtask

   task automatic test_reset_mid_charge();
      int seen0;
      tick(1, 0, 0, 0);
      for (int t = 0; t < 3; t++) tick(1, 0, 0, 1);
      seen0 = shot_seen;
      @(negedge clk);
      #2 resetN = 1'b0;
      #1;
      n_tests++;
      if (topLeftX !== 11'sd440 || topLeftY !== 11'sd224 || sightVisible !== 1'b0 ||
          shotValid !== 1'b0 || shotPower !== 6'd0 || shotDirX !== 8'sd0 || shotDirY !== 8'sd0) begin
         n_fail++;
         $display("FAIL reset_async: (%0d,%0d) vis=%b valid=%b pow=%0d dir=(%0d,%0d) required reset values",
                  topLeftX, topLeftY, sightVisible, shotValid, shotPower, shotDirX, shotDirY);
      end
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      tick(1, 0, 0, 0);
      @(negedge clk);
      n_tests++;
      if (shot_seen != seen0 || sightVisible !== 1'b1 ||
          topLeftX !== 11'sd151 || topLeftY !== 11'sd212) begin
         n_fail++;
         $display("FAIL reset_discard: shots=%0d vis=%b (%0d,%0d) required 0 1 (151,212)",
                  shot_seen - seen0, sightVisible, topLeftX, topLeftY);
      end
   endtask

   initial begin
      test_reset();
      test_arm();
      test_angle_repeat();
      test_left_wrap();
      test_position_wrap();
      test_charge_saturate();
      test_wait_timeout();
      test_back_to_back();
      test_abort();
      test_reset_mid_charge();
      repeat (3) @(negedge clk);
      n_tests++;
      if (shot_q.size() != 0) begin
         n_fail++;
         $display("FAIL shot_missing: %0d expected shots never seen, required 0", shot_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
